vga_hex_writer: RTL and testbench

Upstream feeder of the VGA text-mode display. On each refresh trigger it scans a bank of 32-bit debug words (CPU registers, PC, and similar), converts each word to 8 uppercase hex ASCII characters, and writes them into the display's 80x30 character buffer through its single-byte write port. It runs once per trigger, normally the start of vertical blanking, so the screen tracks live machine state.

---
 rtl/vga_hex_writer_if.sv | 44 ++++
 rtl/vga_hex_writer.sv | 187 ++++++++++++++++++
 tb/tb_vga_hex_writer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_hex_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_hex_writer_if
// Purpose  : Bundles the refresh handshake, the debug-bank read port and the
//            character-buffer write port of vga_hex_writer.
// Revision : 1.0
// ============================================================================
interface vga_hex_writer_if #(
    parameter int NUM_SLOTS = 32
);
    localparam int c_ADDR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                start;
    logic                busy;
    logic                done;
    logic [c_ADDR_W-1:0] dbg_addr;
    logic [31:0]         dbg_data;
    logic                wen;
    logic [11:0]         w_addr;
    logic [7:0]          w_data;

    modport master (
        input  start,
        input  dbg_data,
        output busy,
        output done,
        output dbg_addr,
        output wen,
        output w_addr,
        output w_data
    );

    modport slave (
        output start,
        output dbg_data,
        input  busy,
        input  done,
        input  dbg_addr,
        input  wen,
        input  w_addr,
        input  w_data
    );
endinterface
`default_nettype wire

// File: rtl/vga_hex_writer.sv
`default_nettype none
// ============================================================================
// Module   : vga_hex_writer
// Purpose  : Scans a bank of 32-bit debug words and writes each one as eight
//            uppercase hex characters into the 80x30 text buffer.
// Revision : 1.0
// ============================================================================
module vga_hex_writer #(
    parameter int NUM_SLOTS     = 32,
    parameter int SLOTS_PER_ROW = 4,
    parameter int SLOT_WIDTH    = 20,
    parameter int ROW_BASE      = 2,
    parameter int VALUE_COL     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    vga_hex_writer_if.master bus
);

    localparam int c_ADDR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [c_ADDR_W-1:0] c_LAST_SLOT = c_ADDR_W'(NUM_SLOTS - 1);
    localparam int c_LAST_ADDR = (ROW_BASE + (NUM_SLOTS - 1) / SLOTS_PER_ROW) * 80
                               + ((NUM_SLOTS - 1) % SLOTS_PER_ROW) * SLOT_WIDTH
                               + VALUE_COL + 7;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_LATCH = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    generate
        if (c_LAST_ADDR > 2399) begin : g_bad_layout
            $error("vga_hex_writer: slot layout runs past character address 2399");
        end
    endgenerate

    function automatic logic [11:0] base_addr(input logic [c_ADDR_W-1:0] s);
        int v;
        v = (ROW_BASE + int'(s) / SLOTS_PER_ROW) * 80
          + (int'(s) % SLOTS_PER_ROW) * SLOT_WIDTH + VALUE_COL;
        return v[11:0];
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    logic [2:0]          r_state;
    logic [c_ADDR_W-1:0] r_slot;
    logic [2:0]          r_nib;
    logic [31:0]         r_word;
    logic                r_pending;

    logic [2:0]          w_state_nxt;
    logic [c_ADDR_W-1:0] w_slot_nxt;
    logic [2:0]          w_nib_nxt;
    logic [31:0]         w_word_nxt;
    logic                w_pending_nxt;

    logic                r_busy;
    logic                r_done;
    logic                r_wen;
    logic [11:0]         r_w_addr;
    logic [7:0]          r_w_data;
    logic [c_ADDR_W-1:0] r_dbg_addr;

    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_wen_nxt;
    logic [11:0]         w_w_addr_nxt;
    logic [7:0]          w_w_data_nxt;
    logic [c_ADDR_W-1:0] w_dbg_addr_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_ST_IDLE;
            r_slot    <= '0;
            r_nib     <= 3'd0;
            r_word    <= 32'd0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_slot    <= w_slot_nxt;
            r_nib     <= w_nib_nxt;
            r_word    <= w_word_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // A start seen anywhere but IDLE is remembered; DONE consumes it together
    // with a start arriving in that same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_slot_nxt    = r_slot;
        w_nib_nxt     = r_nib;
        w_word_nxt    = r_word;
        w_pending_nxt = r_pending | bus.start;
        case (r_state)
            c_ST_IDLE: begin
                w_pending_nxt = 1'b0;
                if (bus.start) begin
                    w_state_nxt = c_ST_FETCH;
                    w_slot_nxt  = '0;
                end
            end
            c_ST_FETCH: begin
                w_state_nxt = c_ST_LATCH;
            end
            c_ST_LATCH: begin
                w_word_nxt  = bus.dbg_data;
                w_nib_nxt   = 3'd0;
                w_state_nxt = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                if (r_nib == 3'd7) begin
                    if (r_slot == c_LAST_SLOT) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_slot_nxt  = r_slot + c_ADDR_W'(1);
                        w_state_nxt = c_ST_FETCH;
                    end
                end else begin
                    w_nib_nxt = r_nib + 3'd1;
                end
            end
            c_ST_DONE: begin
                w_pending_nxt = 1'b0;
                if (r_pending || bus.start) begin
                    w_state_nxt = c_ST_FETCH;
                    w_slot_nxt  = '0;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        w_busy_nxt     = (w_state_nxt != c_ST_IDLE);
        w_done_nxt     = (w_state_nxt == c_ST_DONE);
        w_wen_nxt      = (w_state_nxt == c_ST_WRITE);
        w_dbg_addr_nxt = r_dbg_addr;
        w_w_addr_nxt   = r_w_addr;
        w_w_data_nxt   = r_w_data;
        if (w_state_nxt == c_ST_FETCH) begin
            w_dbg_addr_nxt = w_slot_nxt;
        end
        if (w_state_nxt == c_ST_WRITE) begin
            w_w_addr_nxt = base_addr(w_slot_nxt) + {9'd0, w_nib_nxt};
            w_w_data_nxt = hex_char(w_word_nxt[{~w_nib_nxt, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wen      <= 1'b0;
            r_w_addr   <= 12'd0;
            r_w_data   <= 8'd0;
            r_dbg_addr <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_wen      <= w_wen_nxt;
            r_w_addr   <= w_w_addr_nxt;
            r_w_data   <= w_w_data_nxt;
            r_dbg_addr <= w_dbg_addr_nxt;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.wen      = r_wen;
    assign bus.w_addr   = r_w_addr;
    assign bus.w_data   = r_w_data;
    assign bus.dbg_addr = r_dbg_addr;

endmodule
`default_nettype wire

// File: tb/tb_vga_hex_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_hex_writer
// Purpose  : Self-checking bench for vga_hex_writer against a cycle-count model.
// Revision : 1.0
// ============================================================================
module tb_vga_hex_writer;

    localparam int c_SLOTS    = 32;
    localparam int c_SCAN_LEN = c_SLOTS * 10 + 1;
    localparam logic [7:0] c_S0  [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44};
    localparam logic [7:0] c_S31 [8] = '{8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    vga_hex_writer_if #(.NUM_SLOTS(c_SLOTS)) bus ();

    vga_hex_writer #(
        .NUM_SLOTS    (c_SLOTS),
        .SLOTS_PER_ROW(4),
        .SLOT_WIDTH   (20),
        .ROW_BASE     (2),
        .VALUE_COL    (4)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] mem [c_SLOTS];
    logic [7:0]  scr [2400];
    string       hexdig = "0123456789ABCDEF";

    // Model: position within the current scan counted in cycles (1..321).
    logic        m_act  = 1'b0;
    int          m_t    = 0;
    logic        m_pend = 1'b0;
    logic        m_zero = 1'b1;
    logic [31:0] m_word = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_base(input int s);
        return (2 + s / 4) * 80 + (s % 4) * 20 + 4;
    endfunction

    // Scan-position model plus the debug bank: valid data only in LATCH cycles.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_act        <= 1'b0;
            m_t          <= 0;
            m_pend       <= 1'b0;
            m_zero       <= 1'b1;
            bus.dbg_data <= 32'd0;
        end else begin
            logic a;
            logic p;
            int   t;
            a = m_act;
            p = m_pend;
            t = m_t;
            if (!a) begin
                if (bus.start) begin
                    a = 1'b1;
                    t = 1;
                    p = 1'b0;
                end
            end else if (t == c_SCAN_LEN) begin
                if (p || bus.start) begin
                    t = 1;
                    p = 1'b0;
                end else begin
                    a = 1'b0;
                end
            end else begin
                if (bus.start) p = 1'b1;
                t = t + 1;
            end
            m_act  <= a;
            m_pend <= p;
            m_t    <= t;
            if (a) m_zero <= 1'b0;
            if (a && t < c_SCAN_LEN && (t - 1) % 10 == 1) begin
                bus.dbg_data <= mem[bus.dbg_addr];
                m_word       <= mem[(t - 1) / 10];
            end else begin
                bus.dbg_data <= $urandom;
            end
        end
    end

    always @(negedge clk) begin
        int   slot;
        int   ph;
        logic ew;
        slot = (m_t - 1) / 10;
        ph   = (m_t - 1) % 10;
        ew   = m_act && m_t < c_SCAN_LEN && ph >= 2;
        chk("busy", bus.busy, m_act);
        chk("done", bus.done, m_act && m_t == c_SCAN_LEN);
        chk("wen", bus.wen, ew);
        if (ew) begin
            chk("w_addr", bus.w_addr, exp_base(slot) + ph - 2);
            chk("w_data", bus.w_data, hexdig[int'((m_word >> (28 - 4 * (ph - 2))) & 32'hF)]);
        end
        if (m_act && m_t < c_SCAN_LEN && ph == 0) chk("dbg_addr", bus.dbg_addr, slot);
        if (m_zero) begin
            chk("rst_w_addr", bus.w_addr, 0);
            chk("rst_w_data", bus.w_data, 0);
            chk("rst_dbg_addr", bus.dbg_addr, 0);
        end
        if (bus.wen === 1'b1 && bus.w_addr < 12'd2400) scr[bus.w_addr] <= bus.w_data;
    end

    // Leaves the bench one step after the edge that sampled start (E0).
    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic scan_pair(input int p0, input int p1, input int p2);
        int n_done;
        int d1;
        int d2;
        int idle_at;
        n_done  = 0;
        d1      = 0;
        d2      = 0;
        idle_at = 0;
        pulse_start();
        for (int c = 1; c <= 650; c++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (n_done == 1) d1 = c;
                else d2 = c;
            end
            if (!bus.busy && idle_at == 0) idle_at = c;
            bus.start = (c == p0 || c == p1 || c == p2);
        end
        bus.start = 1'b0;
        chk("pair_done_pulses", n_done, 2);
        chk("pair_first_done", d1, 321);
        chk("pair_second_done", d2, 642);
        chk("pair_first_idle", idle_at, 643);
    endtask

    initial begin
        int wen_cnt;
        int done_at;
        logic b1;
        logic b322;
        bus.start = 1'b0;
        for (int i = 0; i < 2400; i++) scr[i] = 8'h00;
        for (int i = 0; i < c_SLOTS; i++) mem[i] = $urandom;
        mem[0]  = 32'h0123ABCD;
        mem[5]  = 32'hFFFFFFFF;
        mem[31] = 32'h89ABCDEF;

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Single scan: timing and literal screen contents.
        wen_cnt = 0;
        done_at = 0;
        b1      = 1'b0;
        b322    = 1'b1;
        pulse_start();
        for (int c = 1; c <= 325; c++) begin
            @(negedge clk);
            if (bus.wen) wen_cnt++;
            if (bus.done && done_at == 0) done_at = c;
            if (c == 1) b1 = bus.busy;
            if (c == 322) b322 = bus.busy;
        end
        chk("busy_cycle1", b1, 1);
        chk("done_cycle", done_at, 321);
        chk("busy_cycle322", b322, 0);
        chk("wen_cycles", wen_cnt, 256);
        for (int i = 0; i < 8; i++) begin
            chk("slot0_char", scr[164 + i], c_S0[i]);
            chk("slot5_char", scr[264 + i], 8'h46);
            chk("slot31_char", scr[784 + i], c_S31[i]);
        end

        // New bank contents, then repeated and DONE-coincident requests.
        for (int i = 0; i < c_SLOTS; i++) mem[i] = $urandom;
        repeat (5) @(posedge clk);
        scan_pair(40, 150, 290);
        repeat (5) @(posedge clk);
        for (int i = 0; i < c_SLOTS; i++) mem[i] = $urandom;
        scan_pair(321, 321, 321);
        repeat (5) @(posedge clk);

        // Asynchronous abort in the middle of slot 4.
        pulse_start();
        repeat (43) @(posedge clk);
        #3;
        chk("wen_before_abort", bus.wen, 1);
        rstn = 1'b0;
        #1;
        chk("abort_wen", bus.wen, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_w_addr", bus.w_addr, 0);
        chk("abort_w_data", bus.w_data, 0);
        chk("abort_dbg_addr", bus.dbg_addr, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        wen_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.wen || bus.busy) wen_cnt++;
        end
        chk("idle_after_abort", wen_cnt, 0);

        // Random requests and bank updates.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            bus.start = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) mem[$urandom_range(0, c_SLOTS - 1)] = $urandom;
        end
        bus.start = 1'b0;
        repeat (700) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
